// File: rtl/spi_mem_arbiter.sv
// Arbiter sharing one SPI RAM transaction engine between the instruction-fetch and data ports.
// Runs one transaction at a time, returns read data to the winner and aborts a hung engine.
module spi_mem_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              owner,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [STARVE_W-1:0] starve_cnt;

    logic grant_any;
    logic grant_data;
    logic starved;

    // Data normally wins contention; fetch wins once it has been passed over often enough.
    always_comb begin
        starved    = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
        grant_any  = if_req | d_req;
        grant_data = d_req & (~if_req | ~starved);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            wait_cnt    <= '0;
            starve_cnt  <= '0;
            if_rdata    <= '0;
            if_done     <= 1'b0;
            d_rdata     <= '0;
            d_done      <= 1'b0;
            mem_start   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            owner       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mem_start <= 1'b0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant_any) begin
                        owner     <= grant_data;
                        mem_we    <= grant_data & d_we;
                        mem_addr  <= grant_data ? d_addr : if_addr;
                        mem_wdata <= grant_data ? d_wdata : '0;
                        if (!grant_data) begin
                            starve_cnt <= '0;
                        end else if (if_req && !starved) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                        mem_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    wait_cnt <= '0;
                    state    <= StWait;
                end
                StWait: begin
                    // A completion arriving on the last allowed cycle still counts as success.
                    if (mem_done) begin
                        if (!mem_we) begin
                            if (owner) d_rdata <= mem_rdata;
                            else       if_rdata <= mem_rdata;
                        end
                        if_done <= ~owner;
                        d_done  <= owner;
                        state   <= StResp;
                    end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        if (!mem_we) begin
                            if (owner) d_rdata <= '0;
                            else       if_rdata <= '0;
                        end
                        if_done <= ~owner;
                        d_done  <= owner;
                        state   <= StResp;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StResp: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: engine model plus a transaction scoreboard.
`timescale 1ns/1ps
module tb_spi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        mem_start;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_done = 1'b0;
    logic        owner;
    logic        busy;
    logic        timeout_err;

    spi_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        own;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          delay;
        logic        hang;
    } txn_t;

    txn_t        txn_q[$];
    txn_t        inflight[$];
    txn_t        mon_t;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_if = '0;
    logic [15:0] exp_d = '0;
    int          eng_cnt = 0;
    logic        eng_active = 1'b0;
    logic [15:0] eng_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic own, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdata,
                        input int delay, input logic hang);
        txn_t t;
        t.own = own; t.we = we; t.addr = addr; t.wdata = wdata;
        t.rdata = rdata; t.delay = delay; t.hang = hang;
        txn_q.push_back(t);
    endtask

    task automatic wait_dones(input int n, input string tag);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (if_done || d_done) seen++;
        end
        check(tag, seen, n);
    endtask

    task automatic wait_start(input string tag);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mem_start && cyc < 20);
        check(tag, mem_start, 1'b1);
    endtask

    // Engine model and scoreboard: checks the issued transaction and every completion.
    always @(negedge clk) begin
        if (!rst_n) begin
            inflight.delete();
            eng_active = 1'b0;
            mem_done = 1'b0;
            exp_if = '0;
            exp_d = '0;
        end else begin
            mem_done = 1'b0;
            if (if_done || d_done) begin
                if (inflight.size() == 0) begin
                    check("unexpected_done", {30'd0, if_done, d_done}, 32'd0);
                end else begin
                    mon_t = inflight.pop_front();
                    check("done_excl", if_done & d_done, 1'b0);
                    check("done_owner", d_done, mon_t.own);
                    check("done_busy", busy, 1'b1);
                    if (!mon_t.own) exp_if = mon_t.hang ? 16'h0 : mon_t.rdata;
                    else if (!mon_t.we) exp_d = mon_t.hang ? 16'h0 : mon_t.rdata;
                    check("if_rdata", if_rdata, exp_if);
                    check("d_rdata", d_rdata, exp_d);
                end
            end
            if (eng_active) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    mem_done = 1'b1;
                    mem_rdata = eng_data;
                    eng_active = 1'b0;
                end
            end
            if (mem_start) begin
                if (txn_q.size() == 0) begin
                    check("unexpected_start", mem_start, 1'b0);
                end else begin
                    mon_t = txn_q.pop_front();
                    check("start_overlap", inflight.size(), 0);
                    check("start_owner", owner, mon_t.own);
                    check("start_we", mem_we, mon_t.we);
                    check("start_addr", mem_addr, mon_t.addr);
                    if (mon_t.we) check("start_wdata", mem_wdata, mon_t.wdata);
                    inflight.push_back(mon_t);
                    eng_cnt = mon_t.delay;
                    eng_data = mon_t.rdata;
                    eng_active = !mon_t.hang;
                end
            end
        end
    end

    initial begin
        int cyc;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_start", mem_start, 1'b0);
        check("rst_if_rdata", if_rdata, 16'h0);
        check("rst_d_rdata", d_rdata, 16'h0);
        check("rst_owner", owner, 1'b0);
        check("rst_terr", timeout_err, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        // T1: fetch only, exact latency
        push(1'b0, 1'b0, 16'h0010, 16'h0, 16'hA5A5, 2, 1'b0);
        @(posedge clk); #1 if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk); check("t1_no_start_yet", mem_start, 1'b0);
        @(negedge clk); check("t1_start", mem_start, 1'b1);
        check("t1_busy", busy, 1'b1);
        repeat (2) @(negedge clk);
        check("t1_not_done_early", if_done, 1'b0);
        @(negedge clk); check("t1_if_done", if_done, 1'b1);
        if_req = 1'b0;
        @(negedge clk); check("t1_idle", busy, 1'b0);
        check("t1_done_pulse", if_done, 1'b0);

        // T2: data write leaves d_rdata untouched
        push(1'b1, 1'b1, 16'h8000, 16'h1234, 16'hDEAD, 3, 1'b0);
        @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 16'h8000; d_wdata = 16'h1234;
        wait_dones(1, "t2_done");
        d_req = 1'b0;
        check("t2_owner", owner, 1'b1);

        // T3: contention, data first then fetch (minimum engine latency)
        push(1'b1, 1'b0, 16'h0200, 16'h0, 16'h1111, 1, 1'b0);
        push(1'b0, 1'b0, 16'h0020, 16'h0, 16'h2222, 1, 1'b0);
        @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        if_req = 1'b1; if_addr = 16'h0020;
        wait_dones(1, "t3_data_done");
        d_req = 1'b0;
        wait_dones(1, "t3_fetch_done");
        if_req = 1'b0;

        // T4: four data wins, then fetch forced; counter cleared afterwards
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 16'h0300, 16'h0, 16'h3000 + 16'(i), 2, 1'b0);
        push(1'b0, 1'b0, 16'h0040, 16'h0, 16'h4444, 2, 1'b0);
        @(posedge clk); #1 d_req = 1'b1; d_addr = 16'h0300; if_req = 1'b1; if_addr = 16'h0040;
        wait_dones(5, "t4_starve_done");
        d_req = 1'b0; if_req = 1'b0;
        push(1'b1, 1'b0, 16'h0300, 16'h0, 16'h5555, 2, 1'b0);
        push(1'b0, 1'b0, 16'h0040, 16'h0, 16'h6666, 2, 1'b0);
        @(posedge clk); #1 d_req = 1'b1; if_req = 1'b1;
        wait_dones(1, "t4_data_again");
        d_req = 1'b0;
        wait_dones(1, "t4_fetch_again");
        if_req = 1'b0;

        // mem_done on the last allowed WAIT cycle is a success
        push(1'b0, 1'b0, 16'h0050, 16'h0, 16'h5A5A, 1024, 1'b0);
        @(posedge clk); #1 if_req = 1'b1; if_addr = 16'h0050;
        wait_dones(1, "edge_done");
        if_req = 1'b0;
        check("edge_no_terr", timeout_err, 1'b0);

        // T5: hung engine times out
        push(1'b0, 1'b0, 16'h0060, 16'h0, 16'h7777, 0, 1'b1);
        @(posedge clk); #1 if_req = 1'b1; if_addr = 16'h0060;
        wait_start("t5_start");
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!if_done && cyc < 1100);
        check("t5_timeout_cycles", cyc, 1025);
        if_req = 1'b0;
        check("t5_terr", timeout_err, 1'b1);
        push(1'b1, 1'b0, 16'h0070, 16'h0, 16'h8888, 2, 1'b0);
        @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0070;
        wait_dones(1, "t5_good_done");
        d_req = 1'b0;
        check("t5_terr_sticky", timeout_err, 1'b1);

        // T6: reset in WAIT drops the transaction
        push(1'b0, 1'b0, 16'h0080, 16'h0, 16'h9999, 0, 1'b1);
        @(posedge clk); #1 if_req = 1'b1; if_addr = 16'h0080;
        wait_start("t6_start");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0; if_req = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_addr", mem_addr, 16'h0);
        check("t6_owner_terr", {owner, timeout_err}, 2'b00);
        check("t6_rdata", {if_rdata, d_rdata}, 32'h0);
        check("t6_done", {if_done, d_done, mem_start}, 3'b000);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if_done || d_done || mem_start) cyc++;
        end
        check("t6_quiet", cyc, 0);
        push(1'b1, 1'b1, 16'h9000, 16'hBEEF, 16'h0, 2, 1'b0);
        @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 16'h9000; d_wdata = 16'hBEEF;
        wait_dones(1, "t6_after_done");
        d_req = 1'b0;
        check("t6_after_terr", timeout_err, 1'b0);
        repeat (3) @(negedge clk);
        check("end_queues", txn_q.size() + inflight.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
